// File: rtl/imm_gen_pkg.sv
// Shared opcode/format constants and the stage-A bundle
// for the pipelined RV32I/RV64I immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_BAD = 3'd7;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  fmt;
    } dec_t;

    // rv64 enables the *W opcode groups; they are illegal otherwise
    function automatic logic [2:0] decode_fmt(
        input logic [6:0] opc,
        input logic       rv64
    );
        logic [2:0] f;
        f = FMT_BAD;
        unique case (1'b1)
            (opc == OPC_OP_IMM),
            (opc == OPC_LOAD),
            (opc == OPC_JALR),
            (opc == OPC_FENCE),
            (opc == OPC_SYSTEM):           f = FMT_I;
            (opc == OPC_STORE):            f = FMT_S;
            (opc == OPC_BRANCH):           f = FMT_B;
            (opc == OPC_LUI),
            (opc == OPC_AUIPC):            f = FMT_U;
            (opc == OPC_JAL):              f = FMT_J;
            (opc == OPC_OP):               f = FMT_R;
            (rv64 && opc == OPC_OP_IMM_32): f = FMT_I;
            (rv64 && opc == OPC_OP_32):    f = FMT_R;
            default:                       f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_assemble.sv
// Combinational immediate assembly: slices the instruction
// by format and sign-extends from instr[31] to XLEN.
module imm_assemble
    import imm_gen_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit BRANCH_SCALED = 1'b0
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0]     raw;
    logic            scale;
    logic [XLEN-1:0] ext;
    logic            unused_opc;

    assign unused_opc = ^instr[6:0];

    always_comb begin
        raw   = '0;
        scale = 1'b0;
        unique case (fmt)
            FMT_I: raw = {{20{instr[31]}}, instr[31:20]};
            FMT_S: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: begin
                raw = {{19{instr[31]}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};
                scale = BRANCH_SCALED;
            end
            FMT_U: raw = {instr[31:12], 12'b0};
            FMT_J: begin
                raw = {{11{instr[31]}}, instr[31], instr[19:12],
                       instr[20], instr[30:21], 1'b0};
                scale = BRANCH_SCALED;
            end
            default: raw = '0;
        endcase
    end

    // raw[31] already carries the sign for every format
    always_comb begin
        ext       = {XLEN{raw[31]}};
        ext[31:0] = raw;
        imm       = ext;
        if (scale) begin
            imm = {ext[XLEN-1], ext[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate generator: stage A decodes
// the format, stage B registers the assembled immediate.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit BRANCH_SCALED = 1'b0,
    parameter bit RV64_OPS      = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam bit USE_RV64 = RV64_OPS && (XLEN == 64);

    logic            a_valid;
    dec_t            a_q;
    logic            b_valid;
    logic [XLEN-1:0] b_imm;
    logic [2:0]      b_fmt;
    logic            b_illegal;

    logic            a_ready;
    logic            b_ready;
    logic            a_load;
    logic            b_load;
    logic [XLEN-1:0] asm_imm;

    assign b_ready  = !b_valid || out_ready;
    assign a_ready  = !a_valid || b_ready;
    assign in_ready = a_ready;
    assign a_load   = in_valid && a_ready;
    assign b_load   = a_valid && b_ready;

    imm_assemble #(
        .XLEN          (XLEN),
        .BRANCH_SCALED (BRANCH_SCALED)
    ) u_asm (
        .instr (a_q.instr),
        .fmt   (a_q.fmt),
        .imm   (asm_imm)
    );

    // Data registers only move on a load, so outputs stay
    // bit-stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid   <= 1'b0;
            a_q       <= '0;
            b_valid   <= 1'b0;
            b_imm     <= '0;
            b_fmt     <= FMT_R;
            b_illegal <= 1'b0;
        end else if (flush) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            if (a_ready) begin
                a_valid <= in_valid;
            end
            if (a_load) begin
                a_q.instr <= instr;
                a_q.fmt   <= decode_fmt(instr[6:0], USE_RV64);
            end
            if (b_ready) begin
                b_valid <= a_valid;
            end
            if (b_load) begin
                b_imm     <= asm_imm;
                b_fmt     <= a_q.fmt;
                b_illegal <= (a_q.fmt == FMT_BAD);
            end
        end
    end

    assign out_valid = b_valid;
    assign imm       = b_imm;
    assign fmt       = b_fmt;
    assign illegal   = b_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit byte-offset build and a
// 64-bit scaled RV64 build driven in lockstep.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;

    logic        in_ready0, out_valid0, illegal0;
    logic [31:0] imm0;
    logic [2:0]  fmt0;
    logic        in_ready1, out_valid1, illegal1;
    logic [63:0] imm1;
    logic [2:0]  fmt1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .BRANCH_SCALED(1'b0), .RV64_OPS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .instr(instr),
        .out_valid(out_valid0), .out_ready(out_ready),
        .imm(imm0), .fmt(fmt0), .illegal(illegal0)
    );

    imm_gen_pipe #(.XLEN(64), .BRANCH_SCALED(1'b1), .RV64_OPS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .instr(instr),
        .out_valid(out_valid1), .out_ready(out_ready),
        .imm(imm1), .fmt(fmt1), .illegal(illegal1)
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA opcode table
    function automatic logic [2:0] m_fmt(input logic [31:0] ins,
                                         input bit rv64);
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: return 3'd1;
            7'h23:        return 3'd2;
            7'h63:        return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h6F:        return 3'd5;
            7'h33:        return 3'd0;
            7'h1B:        return rv64 ? 3'd1 : 3'd7;
            7'h3B:        return rv64 ? 3'd0 : 3'd7;
            default:      return 3'd7;
        endcase
    endfunction

    function automatic logic [63:0] m_imm(input logic [31:0] ins,
                                          input bit wide,
                                          input bit scaled);
        longint v;
        logic signed [11:0] s12;
        logic signed [12:0] b13;
        logic signed [31:0] u32;
        logic signed [20:0] j21;
        v = 0;
        case (m_fmt(ins, wide))
            3'd1: begin s12 = ins[31:20]; v = s12; end
            3'd2: begin s12 = {ins[31:25], ins[11:7]}; v = s12; end
            3'd3: begin
                b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                v = b13;
                if (scaled) v = v / 2;
            end
            3'd4: begin u32 = {ins[31:12], 12'h000}; v = u32; end
            3'd5: begin
                j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                v = j21;
                if (scaled) v = v / 2;
            end
            default: v = 0;
        endcase
        return wide ? 64'(v) : {32'h0, v[31:0]};
    endfunction

    // Scoreboard: instructions currently inside the pipeline
    logic [31:0] sbq[$];
    bit          hold_prev = 1'b0;
    logic [31:0] prev_imm0;
    logic [63:0] prev_imm1;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready0", 64'(in_ready0),
                64'((sbq.size() < 2) || out_ready));
            chk("in_ready1", 64'(in_ready1),
                64'((sbq.size() < 2) || out_ready));
            chk("valid_match", 64'(out_valid1), 64'(out_valid0));
            if (out_valid0) begin
                if (sbq.size() == 0) begin
                    chk("spurious_valid", 64'(out_valid0), 64'd0);
                end else begin
                    chk("d0_imm", {32'h0, imm0}, m_imm(sbq[0], 1'b0, 1'b0));
                    chk("d0_fmt", 64'(fmt0), 64'(m_fmt(sbq[0], 1'b0)));
                    chk("d0_ill", 64'(illegal0),
                        64'(m_fmt(sbq[0], 1'b0) == 3'd7));
                    chk("d1_imm", imm1, m_imm(sbq[0], 1'b1, 1'b1));
                    chk("d1_fmt", 64'(fmt1), 64'(m_fmt(sbq[0], 1'b1)));
                    chk("d1_ill", 64'(illegal1),
                        64'(m_fmt(sbq[0], 1'b1) == 3'd7));
                end
            end
            if (hold_prev) begin
                chk("hold_valid", 64'(out_valid0), 64'd1);
                chk("hold_imm0", {32'h0, imm0}, {32'h0, prev_imm0});
                chk("hold_imm1", imm1, prev_imm1);
            end
        end
        hold_prev = out_valid0 && !out_ready && !rst && !flush;
        prev_imm0 = imm0;
        prev_imm1 = imm1;
        if (rst || flush) begin
            sbq.delete();
        end else begin
            if (out_valid0 && out_ready && sbq.size() > 0)
                void'(sbq.pop_front());
            if (in_valid && in_ready0)
                sbq.push_back(instr);
        end
    end

    logic [31:0] v_ins [11] = '{
        32'h00700013, 32'hE0700013, 32'hE0700023, 32'h00000163,
        32'h80000063, 32'h12345037, 32'h0040006F, 32'h02000033,
        32'h0000007F, 32'hFFF00013, 32'h0010001B};
    logic [31:0] v_imm0 [11] = '{
        32'h00000007, 32'hFFFFFE07, 32'hFFFFFE00, 32'h00000002,
        32'hFFFFF000, 32'h12345000, 32'h00000004, 32'h00000000,
        32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    logic [2:0] v_fmt0 [11] = '{
        3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7, 3'd1, 3'd7};
    logic [63:0] v_imm1 [11] = '{
        64'h0000000000000007, 64'hFFFFFFFFFFFFFE07,
        64'hFFFFFFFFFFFFFE00, 64'h0000000000000001,
        64'hFFFFFFFFFFFFF800, 64'h0000000012345000,
        64'h0000000000000002, 64'h0000000000000000,
        64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF,
        64'h0000000000000001};
    logic [2:0] v_fmt1 [11] = '{
        3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7, 3'd1, 3'd1};

    // Entered and left just after a rising edge, out_ready high
    task automatic send_vec(input int i);
        in_valid = 1'b1;
        instr    = v_ins[i];
        @(posedge clk); #1;
        in_valid = 1'b0;
        instr    = '0;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("lat_valid[%0d]", i), 64'(out_valid0), 64'd1);
        chk($sformatf("lit_imm0[%0d]", i), {32'h0, imm0}, {32'h0, v_imm0[i]});
        chk($sformatf("lit_fmt0[%0d]", i), 64'(fmt0), 64'(v_fmt0[i]));
        chk($sformatf("lit_ill0[%0d]", i), 64'(illegal0),
            64'(v_fmt0[i] == 3'd7));
        chk($sformatf("lit_imm1[%0d]", i), imm1, v_imm1[i]);
        chk($sformatf("lit_fmt1[%0d]", i), 64'(fmt1), 64'(v_fmt1[i]));
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(out_valid0), 64'd0);
        chk("rst_imm", {32'h0, imm0}, 64'd0);
        chk("rst_fmt", 64'(fmt0), 64'd0);
        chk("rst_ill", 64'(illegal0), 64'd0);
        chk("rst_in_ready", 64'(in_ready0), 64'd1);
        mon_en = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) send_vec(i);

        // Backpressure: three offered, two accepted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = v_ins[0];
        @(posedge clk); #1 instr = v_ins[3];
        @(posedge clk); #1 instr = v_ins[5];
        @(negedge clk);
        chk("bp_full_ready", 64'(in_ready0), 64'd0);
        chk("bp_valid", 64'(out_valid0), 64'd1);
        chk("bp_imm_a", {32'h0, imm0}, 64'h7);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_still_full", 64'(in_ready0), 64'd0);
        chk("bp_imm_b", {32'h0, imm0}, 64'h7);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_comb_ready", 64'(in_ready0), 64'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("drain1_valid", 64'(out_valid0), 64'd1);
        chk("drain1_imm", {32'h0, imm0}, 64'h2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain2_valid", 64'(out_valid0), 64'd1);
        chk("drain2_imm", {32'h0, imm0}, 64'h12345000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_empty", 64'(out_valid0), 64'd0);
        @(posedge clk); #1;

        // Flush with both stages full and an input accepted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = v_ins[1];
        @(posedge clk); #1 instr = v_ins[2];
        @(posedge clk); #1;
        instr     = v_ins[4];
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        chk("pre_flush_valid", 64'(out_valid0), 64'd1);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 64'(out_valid0), 64'd0);
        chk("flush_ready", 64'(in_ready0), 64'd1);
        @(posedge clk); #1;
        send_vec(6);

        // Reset while a result is being presented
        in_valid = 1'b1;
        instr    = v_ins[1];
        @(posedge clk); #1 instr = v_ins[5];
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_valid", 64'(out_valid0), 64'd1);
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 64'(out_valid0), 64'd0);
        chk("mrst_imm0", {32'h0, imm0}, 64'd0);
        chk("mrst_imm1", imm1, 64'd0);
        chk("mrst_fmt", 64'(fmt0), 64'd0);
        chk("mrst_ill", 64'(illegal0), 64'd0);
        chk("mrst_ready", 64'(in_ready0), 64'd1);
        @(posedge clk); #1;
        send_vec(9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
